// File: rtl/multicycle_sequencer_if.sv
// Handshake bundle between the multicycle sequencer and its controller/memories.
// The master drives decode/ready inputs; the slave (sequencer) drives enables and status.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             halt_req;
  logic             mem_access;
  logic             reg_write_req;
  logic             imem_ready;
  logic             dmem_ready;
  logic             step_mode;
  logic             step_pulse;
  logic             if_en;
  logic             id_en;
  logic             exe_en;
  logic             mem_en;
  logic             wb_en;
  logic             pc_en;
  logic [2:0]       state;
  logic             fault;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;

  modport master (
    output run, halt_req, mem_access, reg_write_req,
    output imem_ready, dmem_ready, step_mode, step_pulse,
    input  if_en, id_en, exe_en, mem_en, wb_en, pc_en,
    input  state, fault, cycle_count, instret_count
  );

  modport slave (
    input  run, halt_req, mem_access, reg_write_req,
    input  imem_ready, dmem_ready, step_mode, step_pulse,
    output if_en, id_en, exe_en, mem_en, wb_en, pc_en,
    output state, fault, cycle_count, instret_count
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Handshaked fetch/decode/execute/memory/write sequencer with memory-wait timeout and
// saturating cycle/instret counters. Define SEQ_STEP_EN to enable single-step control.
module multicycle_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_sequencer_if.slave bus
);

  localparam int               WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_EXECUTE = 3'b011,
    S_MEMORY  = 3'b100,
    S_WRITE   = 3'b101,
    S_FAULT   = 3'b110,
    S_HALT    = 3'b111
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cycle_q, instret_q;
  logic              fault_q;
  logic              if_q, id_q, exe_q, mem_q, pc_q, wbsel_q;
  logic              start_s;
  logic              timeout_s;
  logic              active_s;

`ifdef SEQ_STEP_EN
  logic step_pulse_q;

  // Remember the previous step_pulse level so one pulse launches exactly one instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pulse_q <= 1'b0;
    end else begin
      step_pulse_q <= bus.step_pulse;
    end
  end

  assign start_s = bus.run | (bus.step_pulse & ~step_pulse_q);
`else
  logic unused_s;
  assign unused_s = bus.step_mode ^ bus.step_pulse;
  assign start_s  = bus.run;
`endif

  assign timeout_s = (TIMEOUT != 0) && (wait_q == TIMEOUT_V);
  assign active_s  = (state_q == S_FETCH)   || (state_q == S_DECODE) ||
                     (state_q == S_EXECUTE) || (state_q == S_MEMORY) ||
                     (state_q == S_WRITE);

  // Next-state and wait-counter logic; ready always wins over an expiring timeout.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.imem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (bus.halt_req) begin
          state_d = S_HALT;
        end else if (bus.mem_access) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_MEMORY: begin
        if (bus.dmem_ready) begin
          state_d = S_WRITE;
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_MEMORY;
        end
      end
      S_WRITE: begin
`ifdef SEQ_STEP_EN
        if (bus.step_mode) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
`else
        state_d = S_FETCH;
`endif
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (((state_q == S_FETCH) || (state_q == S_MEMORY)) && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // State register with enables decoded from the next state so they leave the flops cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= {WAIT_W{1'b0}};
      fault_q <= 1'b0;
      if_q    <= 1'b0;
      id_q    <= 1'b0;
      exe_q   <= 1'b0;
      mem_q   <= 1'b0;
      pc_q    <= 1'b0;
      wbsel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_q | (state_d == S_FAULT);
      if_q    <= (state_d == S_FETCH);
      id_q    <= (state_d == S_DECODE);
      exe_q   <= (state_d == S_EXECUTE) || (state_d == S_MEMORY) || (state_d == S_WRITE);
      mem_q   <= (state_d == S_MEMORY)  || (state_d == S_WRITE);
      pc_q    <= (state_d == S_WRITE);
      wbsel_q <= (state_d == S_WRITE);
    end
  end

  // Saturating activity counters; they freeze once HALT or FAULT is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= {CNT_W{1'b0}};
      instret_q <= {CNT_W{1'b0}};
    end else begin
      if (active_s && (cycle_q != CNT_MAX)) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end else begin
        cycle_q <= cycle_q;
      end
      if ((state_q == S_WRITE) && (instret_q != CNT_MAX)) begin
        instret_q <= instret_q + CNT_W'(1);
      end else begin
        instret_q <= instret_q;
      end
    end
  end

  assign bus.state         = state_q;
  assign bus.fault         = fault_q;
  assign bus.if_en         = if_q;
  assign bus.id_en         = id_q;
  assign bus.exe_en        = exe_q;
  assign bus.mem_en        = mem_q;
  assign bus.pc_en         = pc_q;
  assign bus.wb_en         = wbsel_q & bus.reg_write_req;
  assign bus.cycle_count   = cycle_q;
  assign bus.instret_count = instret_q;

endmodule
